// File: rtl/display_pkg.sv
// Shared constants and FSM encoding for the seven-segment display scanner.
package display_pkg;

  localparam logic [3:0] DIG_DASH  = 4'd10;
  localparam logic [3:0] DIG_BLANK = 4'd15;

  localparam int MAX_DISP = 9999;
  localparam int MIN_DISP = -999;

  // One magnitude bit is consumed per conversion step.
  localparam int unsigned BCD_STEPS = 14;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_FORMAT
  } state_e;

endpackage

// File: rtl/display_scanner_if.sv
// Load/display bus between a value producer (master) and the scanner (slave).
interface display_scanner_if;
  logic [14:0] value;
  logic        load;
  logic        pointEn;
  logic [1:0]  pointPos;
  logic        busy;
  logic [3:0]  digit;
  logic        showPoint;
  logic [3:0]  anode;

  modport master (
    output value, load, pointEn, pointPos,
    input  busy, digit, showPoint, anode
  );

  modport slave (
    input  value, load, pointEn, pointPos,
    output busy, digit, showPoint, anode
  );
endinterface

// File: rtl/bcd_converter.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-add-3, MSB first).
module bcd_converter
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [13:0] bin_i,
  output logic        done_o,
  output logic [15:0] bcd_o
);

  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  step_q, step_d;
  logic        active_q, active_d;
  logic [15:0] adj;
  logic [29:0] shifted;

  // done_o marks the cycle whose clock edge performs the final step, so
  // bcd_o holds the complete result from the following cycle onward.
  assign done_o = active_q && (step_q == 4'(BCD_STEPS - 1));
  assign bcd_o  = bcd_q;

  // Add-3 correction on every BCD nibble that is 5 or more, then shift.
  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {adj, bin_q} << 1;
  end

  // Next-state for the shift register and step counter.
  always_comb begin
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    step_d   = step_q;
    active_d = active_q;
    if (start_i) begin
      bin_d    = bin_i;
      bcd_d    = '0;
      step_d   = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      {bcd_d, bin_d} = shifted;
      step_d         = step_q + 4'd1;
      if (done_o) active_d = 1'b0;
    end
  end

  // Conversion state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      step_q   <= '0;
      active_q <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      step_q   <= step_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Four-digit multiplexed display driver: captures a signed value, converts it
// to BCD, formats it (sign, blanking, overflow dashes) and scans the anodes.
module display_scanner
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  display_scanner_if.slave  bus
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);

  state_e      state_q, state_d;
  logic        busy_q;
  logic        sign_q, oor_q, pe_q, pe_d;
  logic [1:0]  pp_q, pp_d;
  logic [3:0]  disp_q [4];
  logic [3:0]  disp_d [4];
  logic [3:0]  fmt    [4];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  anode_q, digit_q;
  logic        sp_q;

  logic        accept, neg, oor, conv_done, lead;
  logic [14:0] mag;
  logic [15:0] bcd;

  assign accept = (state_q == S_IDLE) && bus.load;
  assign neg    = bus.value[14];
  assign mag    = neg ? (~bus.value + 15'd1) : bus.value;
  assign oor    = neg ? (int'(mag) > -MIN_DISP) : (int'(mag) > MAX_DISP);

  bcd_converter u_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept),
    .bin_i   (mag[13:0]),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.load) state_d = S_CONVERT;
      S_CONVERT: if (conv_done) state_d = S_FORMAT;
      S_FORMAT:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM state and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Capture sign, range and point settings on an accepted load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      oor_q  <= 1'b0;
      pe_q   <= 1'b0;
      pp_q   <= '0;
    end else if (accept) begin
      sign_q <= neg;
      oor_q  <= oor;
      pe_q   <= bus.pointEn;
      pp_q   <= bus.pointPos;
    end
  end

  assign pe_d = accept ? bus.pointEn  : pe_q;
  assign pp_d = accept ? bus.pointPos : pp_q;

  // Format the BCD result; a negative sign occupies digit 3 without ending blanking.
  always_comb begin
    lead = 1'b1;
    for (int unsigned i = 0; i < 4; i++) fmt[i] = DIG_BLANK;
    if (oor_q) begin
      for (int unsigned i = 0; i < 4; i++) fmt[i] = DIG_DASH;
    end else begin
      for (int unsigned k = 0; k < 3; k++) begin
        if (sign_q && k == 0) begin
          fmt[3] = DIG_DASH;
        end else if (lead && bcd[4*(3-k) +: 4] == 4'd0) begin
          fmt[3-k] = DIG_BLANK;
        end else begin
          lead     = 1'b0;
          fmt[3-k] = bcd[4*(3-k) +: 4];
        end
      end
      fmt[0] = bcd[3:0];
    end
    for (int unsigned i = 0; i < 4; i++) disp_d[i] = disp_q[i];
    if (state_q == S_FORMAT) begin
      for (int unsigned i = 0; i < 4; i++) disp_d[i] = fmt[i];
    end
  end

  // Display registers, updated together when formatting completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) disp_q[i] <= DIG_BLANK;
    end else begin
      for (int unsigned i = 0; i < 4; i++) disp_q[i] <= disp_d[i];
    end
  end

  // Refresh counter and scan index next state.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CW'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Scanner and registered outputs, computed from next-state values so the
  // outputs line up with the index and display contents they reflect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      anode_q <= 4'b1110;
      digit_q <= DIG_BLANK;
      sp_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      anode_q <= ~(4'b0001 << idx_d);
      digit_q <= disp_d[idx_d];
      sp_q    <= pe_d && (pp_d == idx_d);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.anode     = anode_q;
  assign bus.digit     = digit_q;
  assign bus.showPoint = sp_q;

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner with a fast refresh divider.
module tb_display_scanner;

  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  display_scanner_if bus ();

  display_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release; the lit position follows from it.
  int unsigned cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int npass = 0;
  int nfail = 0;
  int ntotal = 0;

  logic [3:0] exp_disp [4];
  logic       exp_pe;
  logic [1:0] exp_pp;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    ntotal++;
    assert (obs === exp_v) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Reference: decimal digits of |v|, positions beyond the digit count blank,
  // a minus sign in the leftmost position, dashes when it cannot fit.
  function automatic logic [15:0] model(input int v);
    int m, ndig, p;
    logic [15:0] r;
    if (v > 9999 || v < -999) return 16'hAAAA;
    m = (v < 0) ? -v : v;
    ndig = (m >= 1000) ? 4 : (m >= 100) ? 3 : (m >= 10) ? 2 : 1;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = (i < ndig) ? 4'((m / p) % 10) : 4'd15;
      p = p * 10;
    end
    if (v < 0) r[15:12] = 4'd10;
    return r;
  endfunction

  task automatic set_expect(input logic [15:0] p);
    for (int i = 0; i < 4; i++) exp_disp[i] = p[4*i +: 4];
  endtask

  task automatic scan_check(input int n, input string tag);
    int unsigned idx;
    logic [3:0] ea;
    for (int i = 0; i < n; i++) begin
      idx = (cyc / DIV) % 4;
      ea = ~(4'b0001 << idx);
      chk({tag, "_anode"}, 16'(bus.anode), 16'(ea));
      chk({tag, "_digit"}, 16'(bus.digit), 16'(exp_disp[idx]));
      chk({tag, "_point"}, 16'(bus.showPoint), 16'(exp_pe && (exp_pp == 2'(idx))));
      chk({tag, "_idle"}, 16'(bus.busy), 16'd0);
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_load(input int v, input logic pe, input logic [1:0] pp, input string tag);
    int n;
    bus.value = 15'(v);
    bus.pointEn = pe;
    bus.pointPos = pp;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    exp_pe = pe;
    exp_pp = pp;
    wait_idle(n);
    chk({tag, "_busylen"}, 16'(n), 16'd15);
    set_expect(model(v));
    scan_check(16, tag);
  endtask

  initial begin
    int n;
    int v;
    logic signed [14:0] s;

    bus.value = '0;
    bus.load = 1'b0;
    bus.pointEn = 1'b0;
    bus.pointPos = '0;
    exp_pe = 1'b0;
    exp_pp = '0;
    set_expect(16'hFFFF);

    repeat (3) @(negedge clk);
    chk("rst_anode", 16'(bus.anode), 16'h000E);
    chk("rst_digit", 16'(bus.digit), 16'd15);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_point", 16'(bus.showPoint), 16'd0);
    rst_n = 1'b1;
    chk("rel_anode", 16'(bus.anode), 16'h000E);
    chk("rel_digit", 16'(bus.digit), 16'd15);
    scan_check(16, "rotate");

    do_load(1234, 1'b0, 2'd0, "v1234");
    do_load(-42, 1'b0, 2'd0, "vm42");
    do_load(0, 1'b0, 2'd0, "v0");
    do_load(10000, 1'b0, 2'd0, "v10000");
    do_load(-1000, 1'b0, 2'd0, "vm1000");
    do_load(9999, 1'b0, 2'd0, "v9999");
    do_load(-999, 1'b1, 2'd3, "vm999");
    do_load(5, 1'b1, 2'd2, "v5pt");

    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) v = int'($urandom_range(0, 10998)) - 999;
      else begin
        s = 15'($urandom_range(0, 32767));
        v = s;
      end
      do_load(v, 1'(($urandom >> 3) & 1), 2'($urandom_range(0, 3)), "rand");
    end

    // A load pulse during conversion must not disturb the running one.
    bus.value = 15'(777);
    bus.pointEn = 1'b0;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    exp_pe = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      if (n == 5) begin
        bus.value = 15'(4321);
        bus.pointEn = 1'b1;
        bus.load = 1'b1;
      end
      if (n == 6) bus.load = 1'b0;
      @(negedge clk);
    end
    chk("ignore_busylen", 16'(n), 16'd15);
    set_expect(model(777));
    scan_check(16, "ignore");

    // Held load: one idle cycle between back-to-back conversions.
    bus.value = 15'(88);
    bus.pointEn = 1'b0;
    bus.load = 1'b1;
    @(negedge clk);
    wait_idle(n);
    chk("hold_first", 16'(n), 16'd15);
    @(negedge clk);
    chk("hold_restart", 16'(bus.busy), 16'd1);
    bus.load = 1'b0;
    wait_idle(n);
    chk("hold_second", 16'(n), 16'd15);
    set_expect(model(88));
    scan_check(16, "hold");

    // Reset in the middle of a conversion.
    bus.value = 15'(3210);
    bus.pointEn = 1'b1;
    bus.pointPos = 2'd1;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_busy", 16'(bus.busy), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 16'(bus.busy), 16'd0);
    chk("mrst_anode", 16'(bus.anode), 16'h000E);
    chk("mrst_digit", 16'(bus.digit), 16'd15);
    chk("mrst_point", 16'(bus.showPoint), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pe = 1'b0;
    set_expect(16'hFFFF);
    scan_check(32, "postrst");

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles each digit stays lit; legal range 2..2^20.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 value  input  15  two's-complement number to display; sampled only on an accepted load.
REQ-005 load  input  1  capture request for value, pointEn and pointPos; accepted only when busy=0.
REQ-006 pointEn  input  1  enables the decimal point; captured with value.
REQ-007 pointPos  input  2  index of the digit that carries the point (0 = rightmost); captured with value.
REQ-008 busy  output  1  high while a captured value is being converted; load is ignored while high.
REQ-009 digit  output  4  digit code for the active position: 0-9 numeral, 10 dash, 15 blank; drives the seven-segment decoder.
REQ-010 showPoint  output  1  high when the active position carries the decimal point.
REQ-011 anode  output  4  active-low one-hot position select; bit i low lights digit i.

Function
REQ-012 FSM states: IDLE, CONVERT, FORMAT.
REQ-013 Transitions: IDLE->CONVERT on load=1; CONVERT runs exactly 14 cycles, then ->FORMAT; FORMAT->IDLE after 1 cycle.
REQ-014 busy=1 exactly while the state is CONVERT or FORMAT, which is 15 cycles per accepted load.
REQ-015 On acceptance, the FSM latches the sign, the 14-bit magnitude |value|, an out-of-range flag, pointEn and pointPos.
REQ-016 Out of range: value > 9999 or value < -999.
REQ-017 CONVERT performs shift-add-3 binary-to-BCD conversion, one magnitude bit per cycle, MSB first, producing 4 BCD digits.
REQ-018 At the FORMAT->IDLE edge, the 4 display registers update atomically; the old contents stay shown until that edge.
REQ-019 Formatting, out of range: all four display registers = 10 (dash).
REQ-020 Formatting, leading-zero blanking: digits 3..1 hold 15 while they and every more-significant digit are zero; digit 0 is never blanked.
REQ-021 Formatting, negative: digit 3 = 10; digits 2..0 carry the magnitude with blanking as in REQ-020.
REQ-022 Refresh counter counts 0..REFRESH_DIV-1 and wraps.
REQ-023 On wrap, the 2-bit scan index advances 0->1->2->3->0; each anode is therefore low for exactly REFRESH_DIV cycles.
REQ-024 The scanner runs continuously, independent of the FSM state and of busy.
REQ-025 anode = ~(1<<index); digit = display register[index]; showPoint = latched pointEn && latched pointPos == index.
REQ-026 All outputs are driven from registers; there are no combinational input-to-output paths.
REQ-027 load held high: one acceptance per IDLE visit; a still-high load in IDLE after FORMAT starts a new conversion.

Reset
REQ-028 rst_n low immediately forces: state IDLE, busy 0, counter 0, index 0, anode 4'b1110, all display registers 15, digit 15, showPoint 0, latched pointEn 0.
REQ-029 Reset mid-conversion discards the conversion; no partial result ever reaches the display registers.

Structure
REQ-030 Shared package display_pkg holds: DIG_DASH=4'd10, DIG_BLANK=4'd15, the FSM state encoding, and the max/min displayable limits (9999 / -999).
REQ-031 The binary-to-BCD shift-add-3 datapath is a sub-module named bcd_converter with start/done handshake; display_scanner owns the FSM, formatting and scanning.

Verification (bench REFRESH_DIV=4)
REQ-032 Release reset -> anode=1110, digit=15, busy=0; anode rotates 1110,1101,1011,0111 every 4 cycles.
REQ-033 load value=1234 -> busy high 15 cycles; afterwards digits per index 0..3 = 4,3,2,1.
REQ-034 load value=-42 -> index 3..0 show 10,15,4,2; value=0 -> 15,15,15,0.
REQ-035 load value=10000, then value=-1000 -> all four positions show 10 both times.
REQ-036 load value=5 with pointEn=1, pointPos=2 -> showPoint=1 only while anode=1011.
REQ-037 A second load pulsed while busy is ignored; asserting rst_n low at cycle 7 of CONVERT -> all positions blank, busy=0, no stale digits after release.
